// File: rtl/ic_fill_ctrl.sv
// I-cache line fill responder: one line read per miss, beats packed into a line.
// Define IC_FILL_TIMEOUT_EN to add the stalled-bus timeout and sticky fill_err.
module ic_fill_ctrl #(
  parameter int ADDR_W  = 15,
  parameter int LINE_W  = 256,
  parameter int BEAT_W  = 32,
  parameter int NBEATS  = LINE_W / BEAT_W,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_miss,
  input  logic [ADDR_W-1:0] ic_miss_addr,
  output logic [LINE_W-1:0] ic_fill_data,
  output logic              ic_miss_ack,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [BEAT_W-1:0] mem_rdata,
  output logic              fill_busy,
  output logic              fill_err
);

  localparam int CNT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NBEATS - 1);

  typedef enum logic [2:0] {
    IDLE, REQ, RECV, ACK, HOLD
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              timeout;

`ifdef IC_FILL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] to_q, to_d;
  logic            err_q, err_d;
  logic            act;

  // Counter restarts on any bus progress; fires when it would reach TIMEOUT.
  always_comb begin
    to_d    = to_q;
    err_d   = err_q;
    timeout = 1'b0;
    act     = ((state_q == REQ) && mem_gnt) ||
              ((state_q == RECV) && mem_rvalid);
    if ((state_q == REQ) || (state_q == RECV)) begin
      if (act) begin
        to_d = '0;
      end else if (to_q == TO_LAST) begin
        timeout = 1'b1;
        err_d   = 1'b1;
        to_d    = '0;
      end else begin
        to_d = to_q + TO_W'(1);
      end
    end else begin
      to_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_q  <= '0;
      err_q <= 1'b0;
    end else begin
      to_q  <= to_d;
      err_q <= err_d;
    end
  end

  assign fill_err = err_q;
`else
  assign timeout  = 1'b0;
  assign fill_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    line_d  = line_q;
    unique case (state_q)
      IDLE: begin
        if (ic_miss) begin
          addr_d  = ic_miss_addr;
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (timeout) begin
          state_d = IDLE;
        end else if (mem_gnt) begin
          state_d = RECV;
        end
      end
      RECV: begin
        if (timeout) begin
          state_d = IDLE;
        end else if (mem_rvalid) begin
          line_d[cnt_q*BEAT_W +: BEAT_W] = mem_rdata;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            state_d = ACK;
          end
        end
      end
      ACK:  state_d = HOLD;
      // The cache still holds ic_miss while it writes; skip one cycle.
      HOLD: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ic_miss_ack = 1'b0;
    mem_req     = 1'b0;
    fill_busy   = 1'b1;
    unique case (state_q)
      IDLE:    fill_busy   = 1'b0;
      REQ:     mem_req     = 1'b1;
      ACK:     ic_miss_ack = 1'b1;
      default: ;
    endcase
  end

  assign mem_addr     = addr_q;
  assign ic_fill_data = line_q;

endmodule

// File: tb/tb_ic_fill_ctrl.sv
// Scoreboard bench for ic_fill_ctrl: stimulus queues expected lines,
// a negedge monitor checks every ic_miss_ack against the queue.
module tb_ic_fill_ctrl;

  localparam int AW = 15;
  localparam int LW = 256;
  localparam int BW = 32;
  localparam int NB = 8;
`ifdef IC_FILL_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 255;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          ic_miss;
  logic [AW-1:0] ic_miss_addr;
  logic [LW-1:0] ic_fill_data;
  logic          ic_miss_ack;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [BW-1:0] mem_rdata;
  logic          fill_busy;
  logic          fill_err;

  ic_fill_ctrl #(
    .ADDR_W(AW), .LINE_W(LW), .BEAT_W(BW), .NBEATS(NB), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .ic_miss(ic_miss), .ic_miss_addr(ic_miss_addr),
    .ic_fill_data(ic_fill_data), .ic_miss_ack(ic_miss_ack),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .fill_busy(fill_busy), .fill_err(fill_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [LW-1:0] d;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   ack_cnt = 0;
  int   req_cnt = 0;
  logic req_prev = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [LW-1:0] act,
                     input logic [LW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      req_prev = 1'b0;
    end else begin
      if (mem_req && !req_prev) req_cnt++;
      req_prev = mem_req;
    end
    if (ic_miss_ack) begin
      ack_cnt++;
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL ack_unexpected: got ack with empty queue, required none");
      end else begin
        e = q.pop_front();
        chk("line", ic_fill_data, e.d);
        chk("addr", LW'(mem_addr), LW'(e.a));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] mk(input logic [BW-1:0] base);
    logic [LW-1:0] l;
    l = '0;
    for (int k = 0; k < NB; k++) l[k*BW +: BW] = base + BW'(k);
    return l;
  endfunction

  // Full fill with the miss held through ACK and HOLD, dropped in IDLE.
  task automatic do_fill(input logic [AW-1:0] a, input logic [BW-1:0] base,
                         input int gdly, input int gap,
                         input logic [LW-1:0] exp_line);
    int mc;
    int lc;
    ic_miss      = 1'b1;
    ic_miss_addr = a;
    q.push_back('{a, exp_line});
    mc = cyc;
    step();
    chk1("busy_req", fill_busy, 1'b1);
    chk("mem_addr_req", LW'(mem_addr), LW'(a));
    repeat (gdly) begin
      chk1("req_wait", mem_req, 1'b1);
      step();
    end
    mem_gnt = 1'b1;
    chk1("req_at_gnt", mem_req, 1'b1);
    step();
    mem_gnt = 1'b0;
    chk1("req_after_gnt", mem_req, 1'b0);
    lc = cyc;
    for (int k = 0; k < NB; k++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = base + BW'(k);
      lc = cyc;
      step();
      mem_rvalid = 1'b0;
      mem_rdata  = 32'hDEADBEEF;
      if (k != NB - 1) repeat (gap) step();
    end
    chk1("ack_pulse", ic_miss_ack, 1'b1);
    chki("ack_lat", cyc - lc, 1);
    if (gdly == 0 && gap == 0) chki("miss_to_ack", cyc - mc + 1, 11);
    step();
    chk1("ack_once", ic_miss_ack, 1'b0);
    chk1("busy_hold", fill_busy, 1'b1);
    step();
    ic_miss = 1'b0;
    chk1("idle_after", fill_busy, 1'b0);
    chk("line_stable", ic_fill_data, exp_line);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LW-1:0] l1;
    logic [LW-1:0] last;
    int w;
    int acks0;
    l1 = 256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000;
    rst = 1'b1;
    ic_miss = 1'b0;
    ic_miss_addr = '0;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    step();
    step();
    chk1("rst_ack", ic_miss_ack, 1'b0);
    chk1("rst_req", mem_req, 1'b0);
    chk("rst_addr", LW'(mem_addr), '0);
    chk("rst_data", ic_fill_data, '0);
    chk1("rst_busy", fill_busy, 1'b0);
    chk1("rst_err", fill_err, 1'b0);
    rst = 1'b0;
    step();

    do_fill(15'h1A40, 32'h0, 0, 0, l1);
    do_fill(15'h0C60, 32'hA5A5A5A0, 3, 1, mk(32'hA5A5A5A0));
    repeat (3) step();
    chki("no_refill_req", req_cnt, 2);
    do_fill(15'h0020, 32'h12345670, 0, 0, mk(32'h12345670));

    // Reset in the middle of a fill, then stray beats.
    ic_miss = 1'b1;
    ic_miss_addr = 15'h0100;
    mem_gnt = 1'b1;
    step();
    step();
    mem_gnt = 1'b0;
    ic_miss = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_rvalid = 1'b1;
      mem_rdata = 32'h11110000 + BW'(k);
      step();
    end
    mem_rvalid = 1'b0;
    rst = 1'b1;
    #1;
    chk1("mid_rst_ack", ic_miss_ack, 1'b0);
    chk1("mid_rst_req", mem_req, 1'b0);
    chk("mid_rst_addr", LW'(mem_addr), '0);
    chk("mid_rst_data", ic_fill_data, '0);
    chk1("mid_rst_busy", fill_busy, 1'b0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_rvalid = 1'b1;
      mem_rdata = 32'hBAD00000 + BW'(k);
      step();
    end
    mem_rvalid = 1'b0;
    chk("stray_data", ic_fill_data, '0);
    chk1("stray_busy", fill_busy, 1'b0);
    last = mk(32'h22220000);
    do_fill(15'h0100, 32'h22220000, 0, 0, last);

    // Bus noise while idle.
    mem_rvalid = 1'b1;
    mem_gnt = 1'b1;
    mem_rdata = 32'hFFFFFFFF;
    step();
    step();
    mem_rvalid = 1'b0;
    mem_gnt = 1'b0;
    chk1("noise_busy", fill_busy, 1'b0);
    chk1("noise_req", mem_req, 1'b0);
    chk1("noise_ack", ic_miss_ack, 1'b0);
    chk("noise_data", ic_fill_data, last);
    chki("ack_count", ack_cnt, 4);
    chki("req_count", req_cnt, 5);

`ifdef IC_FILL_TIMEOUT_EN
    acks0 = ack_cnt;
    ic_miss = 1'b1;
    ic_miss_addr = 15'h0200;
    step();
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    ic_miss = 1'b0;
    w = 0;
    for (int k = 0; k < 3; k++) begin
      mem_rvalid = 1'b1;
      mem_rdata = 32'h33330000 + BW'(k);
      w = cyc;
      step();
    end
    mem_rvalid = 1'b0;
    acks0 = acks0 + 0;
    begin
      int lc;
      lc = w;
      w = 0;
      while (!fill_err && w < 40) begin
        step();
        w++;
      end
      chk1("to_err", fill_err, 1'b1);
      chki("to_lat", cyc - lc, 17);
    end
    chk1("to_idle", fill_busy, 1'b0);
    repeat (5) step();
    chk1("to_sticky", fill_err, 1'b1);
    chki("to_no_ack", ack_cnt, acks0);
    rst = 1'b1;
    #1;
    chk1("to_rst_clr", fill_err, 1'b0);
    step();
    rst = 1'b0;
    step();
`else
    w = 0;
    acks0 = 0;
    chk1("err_tied", fill_err, 1'b0);
`endif

    chki("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
